// File: rtl/wb_bus_arbiter_if.sv
// wb_bus_arbiter_if
// Bundles every handshake/bus signal of the two-master, one-slave wishbone
// arbiter: the instruction-fetch master (i_*), the load/store master (d_*)
// and the shared slave port.
// Modports:
//   master : the arbiter's view. It owns the slave bus and returns
//            ack/err/data to both masters.
//   slave  : the surrounding environment's view (masters plus memory).
//            Every direction is the reverse of the master modport.
interface wb_bus_arbiter_if;
  // Instruction master
  logic        i_stb_in;
  logic [15:0] i_adr_in;
  logic [15:0] i_instr_out;
  logic        i_akn_out;
  logic        i_err_out;
  // Data master
  logic        d_stb_in;
  logic        d_we_in;
  logic [15:0] d_adr_in;
  logic [15:0] d_data_in;
  logic [15:0] d_data_out;
  logic        d_akn_out;
  logic        d_err_out;
  // Slave bus
  logic [15:0] adr_out;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        we_out;
  logic [3:0]  sel_out;
  logic        stb_out;
  logic        cyc_out;
  logic        akn_in;

  modport master (
    input  i_stb_in, i_adr_in,
    output i_instr_out, i_akn_out, i_err_out,
    input  d_stb_in, d_we_in, d_adr_in, d_data_in,
    output d_data_out, d_akn_out, d_err_out,
    output adr_out, data_out, we_out, sel_out, stb_out, cyc_out,
    input  data_in, akn_in
  );

  modport slave (
    output i_stb_in, i_adr_in,
    input  i_instr_out, i_akn_out, i_err_out,
    output d_stb_in, d_we_in, d_adr_in, d_data_in,
    input  d_data_out, d_akn_out, d_err_out,
    input  adr_out, data_out, we_out, sel_out, stb_out, cyc_out,
    output data_in, akn_in
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
// Shares one 16-bit wishbone slave port between the instruction-fetch master
// (I) and the load/store master (D). Requests are arbitrated only while idle,
// using round-robin on contention. The winner's address, write enable and
// data are latched, and a single bus cycle is run. The acknowledge (plus read
// data) or a timeout error is returned to the owner. Every output is
// registered.
// Ports:
//   clk : bus clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : wb_bus_arbiter_if.master. Carries the master request and response
//         signals and the slave bus.
// Parameters:
//   TIMEOUT : stb cycles without akn_in before abort (2..255)
//   CNT_W   : timeout counter width, 2**CNT_W > TIMEOUT
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  wb_bus_arbiter_if.master         bus
);

  typedef enum logic [1:0] {StIdle, StBusI, StBusD} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_d;  // 1: D was the most recent owner
  logic [15:0]      r_adr;
  logic [15:0]      r_wdata;
  logic             r_we;
  logic [3:0]       r_sel;
  logic             r_stb;
  logic             r_cyc;
  logic [15:0]      r_instr;
  logic             r_i_akn;
  logic             r_i_err;
  logic [15:0]      r_ddata;
  logic             r_d_akn;
  logic             r_d_err;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;

  // A master still holding stb during its own ack/err cycle must not be
  // re-served for the request that was just completed.
  assign w_i_req   = bus.i_stb_in & ~r_i_akn & ~r_i_err;
  assign w_d_req   = bus.d_stb_in & ~r_d_akn & ~r_d_err;
  assign w_grant_i = w_i_req & (~w_d_req | r_last_d);
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_last_d <= 1'b1;
      r_adr    <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_stb    <= 1'b0;
      r_cyc    <= 1'b0;
      r_instr  <= '0;
      r_i_akn  <= 1'b0;
      r_i_err  <= 1'b0;
      r_ddata  <= '0;
      r_d_akn  <= 1'b0;
      r_d_err  <= 1'b0;
    end else begin
      // ack/err are single-cycle pulses
      r_i_akn <= 1'b0;
      r_i_err <= 1'b0;
      r_d_akn <= 1'b0;
      r_d_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_grant_i) begin
            r_state <= StBusI;
            r_adr   <= bus.i_adr_in;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_sel   <= 4'b1111;
            r_stb   <= 1'b1;
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
          end else if (w_grant_d) begin
            r_state <= StBusD;
            r_adr   <= bus.d_adr_in;
            r_wdata <= bus.d_data_in;
            r_we    <= bus.d_we_in;
            r_sel   <= 4'b1111;
            r_stb   <= 1'b1;
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
          end
        end
        StBusI, StBusD: begin
          // An ack in the expiry cycle takes priority over the timeout.
          if (bus.akn_in || (r_cnt == LastCnt)) begin
            r_state <= StIdle;
            r_stb   <= 1'b0;
            r_cyc   <= 1'b0;
            r_sel   <= '0;
            if (r_state == StBusI) begin
              r_last_d <= 1'b0;
              if (bus.akn_in) begin
                r_i_akn <= 1'b1;
                r_instr <= bus.data_in;
              end else begin
                r_i_err <= 1'b1;
              end
            end else begin
              r_last_d <= 1'b1;
              if (bus.akn_in) begin
                r_d_akn <= 1'b1;
                if (!r_we) r_ddata <= bus.data_in;
              end else begin
                r_d_err <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.adr_out     = r_adr;
  assign bus.data_out    = r_wdata;
  assign bus.we_out      = r_we;
  assign bus.sel_out     = r_sel;
  assign bus.stb_out     = r_stb;
  assign bus.cyc_out     = r_cyc;
  assign bus.i_instr_out = r_instr;
  assign bus.i_akn_out   = r_i_akn;
  assign bus.i_err_out   = r_i_err;
  assign bus.d_data_out  = r_ddata;
  assign bus.d_akn_out   = r_d_akn;
  assign bus.d_err_out   = r_d_err;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter
// Directed-vector bench for wb_bus_arbiter (TIMEOUT=16). A small slave model
// raises akn_in on the (waits+1)-th stb cycle. stray_akn injects an ack while
// the arbiter is idle.
module tb_wb_bus_arbiter;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  int   waits;
  int   sw_cnt;
  logic stray_akn;

  wb_bus_arbiter_if bus ();

  wb_bus_arbiter #(
    .TIMEOUT(16),
    .CNT_W  (8)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sw_cnt counts stb cycles already spent waiting in the current transfer.
  always @(posedge clk) begin
    if (bus.stb_out && !bus.akn_in) sw_cnt <= sw_cnt + 1;
    else                            sw_cnt <= 0;
  end
  assign bus.akn_in = stray_akn | (bus.stb_out & (sw_cnt == waits));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stb_n;
    int akn_n;
    int err_n;
    logic any;
    n_vec = 0;
    n_bad = 0;
    waits = 0;
    sw_cnt = 0;
    stray_akn = 1'b0;
    bus.i_stb_in = 1'b0;
    bus.i_adr_in = '0;
    bus.d_stb_in = 1'b0;
    bus.d_we_in = 1'b0;
    bus.d_adr_in = '0;
    bus.d_data_in = '0;
    bus.data_in = '0;
    rst = 1'b0;
    #12;
    check_eq("reset_bus", {bus.adr_out, bus.data_out}, 32'h0);
    check_eq("reset_ctl", {bus.we_out, bus.sel_out, bus.stb_out, bus.cyc_out,
                           bus.i_akn_out, bus.i_err_out, bus.d_akn_out, bus.d_err_out}, 32'h0);
    rst = 1'b1;
    tick();

    // Single fetch with one wait state
    waits = 1;
    bus.data_in = 16'hA5C3;
    bus.i_stb_in = 1'b1;
    bus.i_adr_in = 16'h0010;
    tick();
    check_eq("fetch_start", {bus.stb_out, bus.cyc_out, bus.we_out, bus.sel_out, bus.adr_out},
             {1'b1, 1'b1, 1'b0, 4'hF, 16'h0010});
    bus.i_stb_in = 1'b0;
    tick();
    check_eq("fetch_wait", {bus.stb_out, bus.i_akn_out}, {1'b1, 1'b0});
    tick();
    check_eq("fetch_ack", {bus.stb_out, bus.cyc_out, bus.i_akn_out, bus.d_akn_out, bus.i_instr_out},
             {1'b0, 1'b0, 1'b1, 1'b0, 16'hA5C3});
    tick();
    check_eq("fetch_hold", {bus.i_akn_out, bus.i_instr_out}, {1'b0, 16'hA5C3});

    // Zero-wait data write
    waits = 0;
    bus.d_stb_in = 1'b1;
    bus.d_we_in = 1'b1;
    bus.d_adr_in = 16'h8000;
    bus.d_data_in = 16'h1234;
    tick();
    check_eq("write_start", {bus.stb_out, bus.we_out, bus.adr_out, bus.data_out},
             {1'b1, 1'b1, 16'h8000, 16'h1234});
    bus.d_stb_in = 1'b0;
    tick();
    check_eq("write_ack", {bus.d_akn_out, bus.i_akn_out, bus.stb_out, bus.d_data_out},
             {1'b1, 1'b0, 1'b0, 16'h0000});

    // Contention: last owner was D, so I wins first
    bus.data_in = 16'hBEEF;
    bus.d_we_in = 1'b0;
    bus.i_adr_in = 16'h0100;
    bus.d_adr_in = 16'h0200;
    bus.i_stb_in = 1'b1;
    bus.d_stb_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("cont_grant%0d", k), {bus.stb_out, bus.adr_out},
               {1'b1, (k % 2 == 0) ? 16'h0100 : 16'h0200});
      tick();
      check_eq($sformatf("cont_ack%0d", k), {bus.stb_out, bus.i_akn_out, bus.d_akn_out},
               {1'b0, (k % 2 == 0), (k % 2 == 1)});
    end
    bus.i_stb_in = 1'b0;
    bus.d_stb_in = 1'b0;
    check_eq("cont_rdata", {bus.i_instr_out, bus.d_data_out}, {16'hBEEF, 16'hBEEF});
    tick();

    // Timeout: slave never acks
    waits = 255;
    bus.data_in = 16'h5555;
    bus.d_stb_in = 1'b1;
    bus.d_adr_in = 16'h0300;
    stb_n = 0; akn_n = 0; err_n = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      bus.d_stb_in = 1'b0;
      stb_n += int'(bus.stb_out);
      akn_n += int'(bus.d_akn_out);
      err_n += int'(bus.d_err_out);
    end
    check_eq("to_stb_cycles", stb_n, 16);
    check_eq("to_err_akn", {err_n[15:0], akn_n[15:0]}, {16'd1, 16'd0});
    check_eq("to_data_kept", bus.d_data_out, 16'hBEEF);

    // I served normally after the timeout
    waits = 0;
    bus.data_in = 16'h1111;
    bus.i_stb_in = 1'b1;
    bus.i_adr_in = 16'h0400;
    tick();
    bus.i_stb_in = 1'b0;
    check_eq("post_to_grant", {bus.stb_out, bus.adr_out}, {1'b1, 16'h0400});
    tick();
    check_eq("post_to_ack", {bus.i_akn_out, bus.i_instr_out}, {1'b1, 16'h1111});
    tick();

    // Ack arriving exactly in the expiry cycle wins
    waits = 15;
    bus.data_in = 16'h2222;
    bus.d_stb_in = 1'b1;
    bus.d_adr_in = 16'h0500;
    stb_n = 0; akn_n = 0; err_n = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      bus.d_stb_in = 1'b0;
      stb_n += int'(bus.stb_out);
      akn_n += int'(bus.d_akn_out);
      err_n += int'(bus.d_err_out);
    end
    check_eq("late_stb_cycles", stb_n, 16);
    check_eq("late_akn_err", {akn_n[15:0], err_n[15:0]}, {16'd1, 16'd0});
    check_eq("late_rdata", bus.d_data_out, 16'h2222);

    // Stray ack while idle
    stray_akn = 1'b1;
    tick();
    stray_akn = 1'b0;
    check_eq("stray", {bus.stb_out, bus.cyc_out, bus.i_akn_out, bus.d_akn_out,
                       bus.i_err_out, bus.d_err_out, bus.d_data_out},
             {6'b0, 16'h2222});

    // Reset in the middle of a D cycle
    waits = 255;
    bus.d_stb_in = 1'b1;
    bus.d_adr_in = 16'h0600;
    bus.d_we_in = 1'b1;
    bus.d_data_in = 16'h7777;
    tick();
    bus.d_stb_in = 1'b0;
    tick();
    tick();
    check_eq("pre_abort", {bus.stb_out, bus.adr_out}, {1'b1, 16'h0600});
    #2;
    rst = 1'b0;
    #1;
    check_eq("abort_bus", {bus.adr_out, bus.data_out}, 32'h0);
    check_eq("abort_ctl", {bus.we_out, bus.sel_out, bus.stb_out, bus.cyc_out,
                           bus.i_akn_out, bus.i_err_out, bus.d_akn_out, bus.d_err_out}, 32'h0);
    check_eq("abort_rdata", {bus.i_instr_out, bus.d_data_out}, 32'h0);
    #10;
    rst = 1'b1;
    any = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      any |= bus.i_akn_out | bus.d_akn_out | bus.i_err_out | bus.d_err_out | bus.stb_out;
    end
    check_eq("abort_quiet", any, 1'b0);

    // First contention after reset goes to I
    waits = 0;
    bus.d_we_in = 1'b0;
    bus.data_in = 16'h3333;
    bus.i_adr_in = 16'h0700;
    bus.d_adr_in = 16'h0800;
    bus.i_stb_in = 1'b1;
    bus.d_stb_in = 1'b1;
    tick();
    check_eq("rst_cont_grant", {bus.stb_out, bus.adr_out}, {1'b1, 16'h0700});
    tick();
    check_eq("rst_cont_ack", {bus.i_akn_out, bus.d_akn_out, bus.i_instr_out},
             {1'b1, 1'b0, 16'h3333});
    bus.i_stb_in = 1'b0;
    bus.d_stb_in = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU's 16-bit wishbone bus.
- Shares the single memory port between the instruction-fetch master (I) and the load/store master (D).
- Sequences each bus cycle and drives stb/cyc/we/sel to the slave.
- Returns data and acknowledge to the granted master, and aborts cycles the slave never acknowledges.

Parameters:
- TIMEOUT, 16: max cycles stb_out may stay high without akn_in before the cycle is aborted; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  bus clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- i_stb_in  in  1  instruction master request
- i_adr_in  in  16  fetch address
- i_instr_out  out  16  fetched instruction, valid while i_akn_out=1
- i_akn_out  out  1  one-cycle fetch acknowledge
- i_err_out  out  1  one-cycle fetch timeout error
- d_stb_in  in  1  data master request
- d_we_in  in  1  0 read, 1 write
- d_adr_in  in  16  data address
- d_data_in  in  16  write data
- d_data_out  out  16  read data, valid while d_akn_out=1
- d_akn_out  out  1  one-cycle data acknowledge
- d_err_out  out  1  one-cycle data timeout error
- adr_out  out  16  slave address
- data_out  out  16  slave write data
- data_in  in  16  slave read data
- we_out  out  1  slave write enable
- sel_out  out  4  byte selects
- stb_out  out  1  slave strobe
- cyc_out  out  1  slave cycle
- akn_in  in  1  slave acknowledge

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, counter 0, last_grant=D (so I wins the first contention).
- All outputs are registered.
- States:
  - IDLE: no request (after masking) -> IDLE. Requests present -> BUS_I or BUS_D.
  - BUS_I / BUS_D: exit to IDLE on akn_in or timeout.
- Arbitration (IDLE only):
  - Only one stb high: grant it.
  - Both high: grant the master not equal to last_grant (round-robin).
  - On grant, latch adr/we/data of the winner. I is always we=0, data_out=0.
  - Next cycle stb_out=cyc_out=1, sel_out=4'b1111.
- Masking: a master's stb_in is ignored in any cycle its own akn_out or err_out is high. This prevents double service when the master holds stb through the ack cycle.
- BUS state with akn_in sampled 1:
  - Next cycle stb_out=cyc_out=0, sel_out=0.
  - Owner's akn_out=1 for exactly one cycle; on a read, data_in is registered to the owner's data output.
  - last_grant <= owner; state -> IDLE.
- Latency:
  - Request seen at edge n -> stb_out high after edge n+1.
  - Zero-wait slave (akn_in high in first stb cycle) -> akn_out high after edge n+2.
  - One mandatory IDLE cycle between consecutive transactions.
- Timeout:
  - Counter clears on grant and increments each BUS cycle without akn_in.
  - When stb_out has been high for TIMEOUT cycles with no akn_in: drop stb/cyc, pulse owner's err_out one cycle, no akn_out, data output unchanged, last_grant <= owner, state -> IDLE.
  - akn_in in the same cycle as expiry wins: normal ack, no err.
- akn_in while in IDLE is ignored (no akn/err to anyone).
- Master dropping stb mid-cycle does not abort; the cycle completes and akn/err is still delivered.
- Latched adr/we/data are held constant for the whole BUS state regardless of master inputs.
- Reset asserted mid-cycle: immediate return to reset values, no akn/err emitted.
- i_instr_out/d_data_out hold their last value when not acknowledging.

Test Plan:
- Single fetch: i_stb_in=1, i_adr_in=16'h0010, slave akn_in after 1 wait with data_in=16'hA5C3 -> stb_out/cyc_out high 2 cycles, adr_out=0010, we_out=0, sel_out=F, i_akn_out one pulse with i_instr_out=A5C3, then IDLE.
- Data write: d_stb_in=1, d_we_in=1, d_adr_in=16'h8000, d_data_in=16'h1234, zero-wait slave -> adr_out=8000, data_out=1234, we_out=1, d_akn_out pulses 2 cycles after request, no i_akn_out.
- Contention: both stb held high, zero-wait slave, 4 transactions -> grants in order I, D, I, D, one IDLE cycle between each, each akn to the correct master only.
- Timeout: TIMEOUT=16, d_stb_in=1, akn_in never asserted -> stb_out high exactly 16 cycles, then d_err_out one pulse, d_akn_out stays 0, next I request served normally. Repeat with akn_in on cycle 16 -> d_akn_out, no err.
- Stray/abort: akn_in pulsed in IDLE -> no outputs change. Reset (rst=0) asserted in BUS_D after 3 cycles -> all outputs 0 asynchronously, no akn/err after release; first contention afterwards grants I.
